// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-to-one fetch/data arbiter for a shared SRAM-like port
module sram_req_arbiter #(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTST);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Owner bit per entry: 0 = inst, 1 = data.
  logic                 lock_q, lock_d;
  logic                 lock_owner_q, lock_owner_d;
  logic [MAX_OUTST-1:0] fifo_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;

  logic gnt_vld, gnt_own, full, hs, inst_hs, pop, head;

  assign full = (count_q == FULL_CNT);
  assign head = fifo_q[rd_ptr_q];

  // Grant selection: a stalled request keeps the port; otherwise starved inst, then data, then inst.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_own = 1'b0;
    if (!rst) begin
      if (lock_q) begin
        gnt_vld = 1'b1;
        gnt_own = lock_owner_q;
      end else if (full) begin
        gnt_vld = 1'b0;
      end else if (inst_req && (starve_q == STARVE_MAX)) begin
        gnt_vld = 1'b1;
        gnt_own = 1'b0;
      end else if (data_req) begin
        gnt_vld = 1'b1;
        gnt_own = 1'b1;
      end else if (inst_req) begin
        gnt_vld = 1'b1;
        gnt_own = 1'b0;
      end
    end
  end

  // Payload mux from the grantee; fetch is always a word read.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (gnt_vld && gnt_own) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (gnt_vld) begin
      mem_size  = 2'd2;
      mem_addr  = inst_addr;
    end
  end

  assign mem_req      = gnt_vld;
  assign hs           = gnt_vld & mem_addr_ok;
  assign inst_hs      = hs & ~gnt_own;
  assign inst_addr_ok = inst_hs;
  assign data_addr_ok = hs & gnt_own;

  // Responses with nothing outstanding (e.g. after a reset) are ignored.
  assign pop          = ~rst & mem_data_ok & (count_q != '0);
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign rdata        = mem_rdata;

  // Next-state for lock, occupancy and starvation counter.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (hs) begin
      lock_d = 1'b0;
    end else if (gnt_vld) begin
      lock_d       = 1'b1;
      lock_owner_d = gnt_own;
    end
    count_d = count_q;
    if (hs && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!hs && pop) begin
      count_d = count_q - CW'(1);
    end
    starve_d = starve_q;
    if (!inst_req || inst_hs) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers: order FIFO, pointers, lock and starvation tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      if (hs) begin
        fifo_q[wr_ptr_q] <= gnt_own;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - randomized and directed checks of sram_req_arbiter against a queue model
module tb_sram_req_arbiter;

  localparam int MAXO   = 4;
  localparam int SLIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sram_req_arbiter #(.MAX_OUTST(MAXO), .STARVE_LIMIT(SLIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: queue of owners of accepted requests, a stall latch, a loss counter.
  bit mq[$];
  bit m_lock, m_lock_own;
  int m_starve;
  // Decisions evaluated mid-cycle, applied at the following clock edge.
  bit e_gv, e_go, e_hs, e_ihs, e_pop;

  // Compare process: derive this cycle's expected outputs from the model and current inputs.
  always @(negedge clk) begin
    bit gv, go, pop, hd;
    logic [31:0] x_addr, x_wdata;
    logic [1:0]  x_size;
    logic [3:0]  x_wstrb;
    logic        x_wr;
    gv = 0; go = 0;
    if (!rst) begin
      if (m_lock) begin gv = 1; go = m_lock_own; end
      else if (mq.size() == MAXO) gv = 0;
      else if (inst_req && m_starve == SLIMIT) begin gv = 1; go = 0; end
      else if (data_req) begin gv = 1; go = 1; end
      else if (inst_req) begin gv = 1; go = 0; end
    end
    pop = !rst && mem_data_ok && mq.size() > 0;
    hd  = (mq.size() > 0) ? mq[0] : 1'b0;
    x_wr = 0; x_size = 0; x_wstrb = 0; x_addr = 0; x_wdata = 0;
    if (gv && go) begin
      x_wr = data_wr; x_size = data_size; x_wstrb = data_wstrb;
      x_addr = data_addr; x_wdata = data_wdata;
    end else if (gv) begin
      x_size = 2'd2; x_addr = inst_addr;
    end
    chk("mem_req", {31'd0, mem_req}, {31'd0, gv});
    chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, x_wr, x_size, x_wstrb});
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_wdata", mem_wdata, x_wdata);
    chk("addr_ok", {30'd0, inst_addr_ok, data_addr_ok},
        {30'd0, gv && !go && mem_addr_ok, gv && go && mem_addr_ok});
    chk("data_ok", {30'd0, inst_data_ok, data_data_ok}, {30'd0, pop && !hd, pop && hd});
    chk("rdata", rdata, mem_rdata);
    e_gv  = gv;
    e_go  = go;
    e_hs  = gv && mem_addr_ok;
    e_ihs = gv && !go && mem_addr_ok;
    e_pop = pop;
  end

  // Model state update at the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_lock = 0; m_lock_own = 0; m_starve = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_hs) mq.push_back(e_go);
      if (e_hs) m_lock = 0;
      else if (e_gv) begin m_lock = 1; m_lock_own = e_go; end
      if (!inst_req || e_ihs) m_starve = 0;
      else if (m_starve < SLIMIT) m_starve++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic drain();
    idle_inputs();
    mem_data_ok = 1;
    repeat (MAXO + 1) step();
    mem_data_ok = 0;
  endtask

  initial begin
    int won;
    rst = 1; inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200;
    data_wr = 1; data_size = 2; data_wstrb = 4'hf; data_wdata = 32'h55;
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hdeadbeef;
    samp();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'hdeadbeef);
    step(); step();
    rst = 0; idle_inputs();
    step();

    // Single fetch.
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    samp();
    chk("sf_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("sf_mem_addr", mem_addr, 32'h1c000000);
    chk("sf_mem_size", {30'd0, mem_size}, 32'd2);
    step();
    inst_req = 0; mem_addr_ok = 0;
    step();
    mem_data_ok = 1; mem_rdata = 32'h02800000;
    samp();
    chk("sf_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    chk("sf_rdata", rdata, 32'h02800000);
    step();
    idle_inputs();
    step();

    // Contention: data first, then inst; responses return D then I.
    inst_req = 1; inst_addr = 32'h1c000010; data_req = 1; data_addr = 32'h80000040;
    data_wr = 0; data_size = 2; data_wstrb = 0; mem_addr_ok = 1;
    samp();
    chk("ct_first", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    step();
    data_req = 0;
    samp();
    chk("ct_second", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    samp();
    chk("ct_resp_d", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    step();
    samp();
    chk("ct_resp_i", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    step();
    idle_inputs();
    step();

    // Lock: stalled inst keeps the port while data waits.
    inst_req = 1; inst_addr = 32'h1c000020; mem_addr_ok = 0;
    step();
    data_req = 1; data_addr = 32'h80001000; data_wr = 1; data_wstrb = 4'h3;
    data_size = 1; data_wdata = 32'hcafe;
    samp();
    chk("lk_hold1", mem_addr, 32'h1c000020);
    step();
    samp();
    chk("lk_hold2", mem_addr, 32'h1c000020);
    step();
    mem_addr_ok = 1;
    samp();
    chk("lk_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    step();
    inst_req = 0;
    samp();
    chk("lk_data_addr", mem_addr, 32'h80001000);
    chk("lk_data_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    drain();

    // Full FIFO.
    for (int i = 0; i < MAXO; i++) begin
      inst_req = 1; inst_addr = 32'h1c000100 + 32'(i * 4); mem_addr_ok = 1;
      samp();
      chk("ff_fill", {31'd0, inst_addr_ok}, 32'd1);
      step();
    end
    mem_data_ok = 1;
    samp();
    chk("ff_no_grant", {31'd0, mem_req}, 32'd0);
    chk("ff_pop", {31'd0, inst_data_ok}, 32'd1);
    step();
    mem_data_ok = 0;
    samp();
    chk("ff_regrant", {31'd0, mem_req}, 32'd1);
    step();
    drain();

    // Starvation guard.
    won = 0;
    inst_req = 1; inst_addr = 32'h1c000200; data_req = 1; data_wr = 0;
    data_addr = 32'h80002000; mem_addr_ok = 1;
    for (int n = 1; n <= 20 && won == 0; n++) begin
      mem_data_ok = (n > 1);
      samp();
      if (inst_addr_ok) won = n;
      step();
    end
    chk("sv_win_cycle", 32'(won), 32'd9);
    drain();

    // Reset with requests outstanding.
    inst_req = 1; mem_addr_ok = 1;
    step(); step();
    inst_req = 0; mem_addr_ok = 0; rst = 1;
    samp();
    chk("rm_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    rst = 0; mem_data_ok = 1;
    samp();
    chk("rm_dropped", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    step();
    mem_data_ok = 0;
    for (int i = 0; i < MAXO; i++) begin
      inst_req = 1; mem_addr_ok = 1;
      samp();
      chk("rm_empty", {31'd0, inst_addr_ok}, 32'd1);
      step();
    end
    samp();
    chk("rm_full", {31'd0, mem_req}, 32'd0);
    step();
    idle_inputs(); rst = 1;
    step();
    rst = 0;

    // Randomized traffic; requesters hold until accepted.
    for (int c = 0; c < 4000; c++) begin
      if (!inst_req || e_ihs) begin
        inst_req  = ($urandom_range(0, 99) < 55);
        inst_addr = $urandom;
      end
      if (!data_req || (e_hs && e_go)) begin
        data_req   = ($urandom_range(0, 99) < 55);
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 99) < 60);
      mem_data_ok = (mq.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
      mem_rdata   = $urandom;
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that shares a single SRAM-like memory port between the instruction-fetch requester (IF) and the data-access requester (MEM). Sits between the pipeline and the SRAM-to-AXI bridge. It tracks outstanding requests in order so that each `data_ok` returns to the requester that issued the matching address. Data requests take priority, and a bounded starvation guard protects fetch.

## Interface
- `MAX_OUTST`, 4: maximum accepted-but-unanswered requests; power of two, ≥2.
- `STARVE_LIMIT`, 8: consecutive lost arbitrations after which inst is forced to win.
- Reset is `rst`, synchronous, active-high; the clock is `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `inst_req`  in  1  fetch request, held until `inst_addr_ok`.
- `inst_addr`  in  32  fetch address (read only, size 2).
- `inst_addr_ok`  out  1  fetch address accepted this cycle.
- `inst_data_ok`  out  1  fetch data valid this cycle.
- `data_req`  in  1  data request, held until `data_addr_ok`.
- `data_wr`  in  1  1 = write.
- `data_size`  in  2  0/1/2 = byte/half/word.
- `data_wstrb`  in  4  byte enables.
- `data_addr`  in  32  data address.
- `data_wdata`  in  32  write data.
- `data_addr_ok`  out  1  data address accepted.
- `data_data_ok`  out  1  data response valid.
- `rdata`  out  32  `mem_rdata` broadcast to both requesters.
- `mem_req`  out  1  shared port request.
- `mem_wr`, `mem_size`[2], `mem_wstrb`[4], `mem_addr`[32], `mem_wdata`[32]  out  shared port payload.
- `mem_addr_ok`  in  1  slave accepted the request.
- `mem_data_ok`  in  1  slave response; never in the same cycle as its own `addr_ok`.
- `mem_rdata`  in  32  slave read data.

## Operation
- State:
  - `lock` (0/1) and `lock_owner` (0 = inst, 1 = data).
  - Order FIFO of `MAX_OUTST` one-bit owner entries, with pointers and a count 0..`MAX_OUTST`.
  - Starvation counter `starve` 0..`STARVE_LIMIT`.
- Grant, combinational:
  - If `lock`, the grant is `lock_owner`.
  - Else if FIFO full, there is no grant.
  - Else if `inst_req` and `starve == STARVE_LIMIT`, the grant is inst.
  - Else if `data_req`, the grant is data.
  - Else if `inst_req`, the grant is inst.
  - Else there is no grant.
- Port driving:
  - `mem_req` is 1 whenever a grant exists. Payload is muxed from the granted requester.
  - An inst grant drives `mem_wr=0`, `mem_size=2`, `mem_wstrb=0`, `mem_wdata=0`.
  - With no grant, the payload is all zero.
- Address handshake:
  - Handshake is `mem_req & mem_addr_ok`.
  - The grantee's `*_addr_ok` equals `mem_addr_ok`; the other requester sees 0.
  - On handshake, the owner bit is pushed into the FIFO and `lock` is cleared.
- Lock:
  - If `mem_req=1` and `mem_addr_ok=0`, set `lock=1` and `lock_owner=grant`.
  - The payload stays with that owner until accepted, even if the other requester has higher priority.
- Response:
  - On `mem_data_ok` with FIFO non-empty, pop the head.
  - Head 0 pulses `inst_data_ok`; head 1 pulses `data_data_ok`.
  - `mem_data_ok` with the FIFO empty is dropped: no pulse, no count change.
- Starvation counter:
  - Increments, saturating, on cycles with `inst_req=1` and no inst handshake.
  - Clears on an inst handshake or when `inst_req=0`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full FIFO with a simultaneous pop: the full flag uses the registered count, so no grant is issued that cycle.

## Timing
- Request-to-port path is 0 cycles: `*_req` to `mem_req`, and `mem_addr_ok` to `*_addr_ok`, are combinational.
- Response routing is 0 cycles: `mem_data_ok` to `*_data_ok` is combinational from the registered FIFO head.
- Back-to-back handshakes are sustained, one per cycle, while the FIFO is not full.
- Responses return strictly in acceptance order.
- During `rst`, all outputs are 0; `rdata` follows `mem_rdata`.
- After `rst`: `lock=0`, FIFO empty, `starve=0`.
- Responses arriving after a mid-operation reset are dropped.

## Test plan
- **Single fetch:** `inst_req`=1, addr 0x1c000000; `mem_addr_ok` in cycle 0 and `mem_data_ok` in cycle 2 with rdata 0x02800000 → `inst_addr_ok` in cycle 0, `inst_data_ok` in cycle 2 with `rdata`=0x02800000, `data_data_ok` stays 0.
- **Contention:** both requesters assert in the same cycle → data is granted first; inst is granted the next cycle. Responses D then I → `data_data_ok`, then `inst_data_ok`.
- **Lock:** inst is presented with `mem_addr_ok`=0 for 3 cycles while `data_req` rises in cycle 1 → `mem_addr` stays at the inst address until accepted, then data is granted.
- **Full FIFO:** with `MAX_OUTST`=4, issue 4 accepted reads with no responses → `mem_req`=0 with `inst_req`=1. After one `mem_data_ok`, `mem_req`=1 the next cycle.
- **Starvation:** `data_req` held at 1 with `mem_addr_ok` always 1, and `inst_req`=1 → inst is granted on the 9th cycle (`STARVE_LIMIT`=8).
- **Reset mid-flight:** 2 requests outstanding, `rst` for 1 cycle, then `mem_data_ok` → no `*_data_ok` pulse, and the FIFO count is 0.
